// File: rtl/msg_display_ctrl_pkg.sv
// Shared state codes and message indices for the on-screen message scheduler.
// Message indices double as requester / overlay-stage numbers.
package msg_display_ctrl_pkg;

  typedef enum logic [1:0] {
    MSG_ST_IDLE = 2'd0,
    MSG_ST_ARM  = 2'd1,
    MSG_ST_SHOW = 2'd2,
    MSG_ST_GAP  = 2'd3
  } msg_state_e;

  localparam int MSG_ID_PAIR     = 0;
  localparam int MSG_ID_MISMATCH = 1;
  localparam int MSG_ID_WIN      = 2;
  localparam int MSG_ID_TIMEOUT  = 3;
  localparam int MSG_N_IDS       = 4;

endpackage

// File: rtl/msg_display_ctrl_rr_arbiter.sv
// Combinational round-robin pick: nearest set pending bit after rr_ptr wins.
// Zero latency; no backpressure, the caller decides when to take the winner.
module msg_display_ctrl_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0] sel;

  // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    sel    = '0;
    for (int d = N_REQ; d >= 1; d--) begin
      sel = ID_W'((int'(rr_ptr) + d) % N_REQ);
      if (pending[sel]) begin
        winner = sel;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msg_display_ctrl.sv
// Shares one message area between N_REQ overlays; enables switch only on vsync rising edges.
// req->pending 1 cycle, enable 1 cycle after first tick in ARM; requests never stall, they accumulate.
module msg_display_ctrl
  import msg_display_ctrl_pkg::*;
#(
  parameter int N_REQ       = MSG_N_IDS,
  parameter int ID_W        = 2,
  parameter int CNT_W       = 8,
  parameter int SHOW_FRAMES = 120,
  parameter int GAP_FRAMES  = 15
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vs_in,
  input  logic [N_REQ-1:0] req,
  input  logic             abort,
  output logic [N_REQ-1:0] enable,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_FRAMES - 1);

  msg_state_e       state_q, state_d;
  logic             vs_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] enable_q, enable_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_hold_q, abort_hold_d;

  logic             tick;
  logic [ID_W-1:0]  arb_winner;
  logic             arb_any;

  msg_display_ctrl_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .winner  (arb_winner),
    .any     (arb_any)
  );

  assign tick = vs_in & ~vs_q;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    enable_d     = enable_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    abort_hold_d = abort_hold_q;

    case (state_q)
      MSG_ST_IDLE: begin
        if (!abort && arb_any) begin
          state_d    = MSG_ST_ARM;
          grant_id_d = arb_winner;
          rr_ptr_d   = arb_winner;
          busy_d     = 1'b1;
        end
      end
      MSG_ST_ARM: begin
        if (abort) begin
          state_d = MSG_ST_IDLE;
          busy_d  = 1'b0;
        end else if (tick) begin
          state_d              = MSG_ST_SHOW;
          enable_d             = '0;
          enable_d[grant_id_q] = 1'b1;
          pending_d[grant_id_q] = 1'b0;
          cnt_d                = '0;
        end
      end
      MSG_ST_SHOW: begin
        // An aborted message keeps the overlay up until the frame ends, then vanishes silently.
        if (abort || abort_hold_q) begin
          abort_hold_d = 1'b1;
          if (tick) begin
            state_d      = MSG_ST_IDLE;
            enable_d     = '0;
            busy_d       = 1'b0;
            abort_hold_d = 1'b0;
          end
        end else if (tick) begin
          if (cnt_q == SHOW_LAST) begin
            enable_d = '0;
            done_d   = 1'b1;
            if (GAP_FRAMES == 0) begin
              state_d = MSG_ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = MSG_ST_GAP;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MSG_ST_GAP: begin
        if (abort) begin
          state_d = MSG_ST_IDLE;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (cnt_q == GAP_LAST) begin
            state_d = MSG_ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = MSG_ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A new request beats the ARM-time clear; abort beats everything.
    pending_d = pending_d | req;
    if (abort) begin
      pending_d = '0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MSG_ST_IDLE;
      vs_q         <= 1'b0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      enable_q     <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_in;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      enable_q     <= enable_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_hold_q <= abort_hold_d;
    end
  end

  assign enable   = enable_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_msg_display_ctrl.sv
// Bench for msg_display_ctrl: directed frame-level table, hand sequences, random vs model.
module tb_msg_display_ctrl;
  import msg_display_ctrl_pkg::*;

  localparam int SHOW      = 3;
  localparam int GAP       = 2;
  localparam int VS_PERIOD = 20;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs_in = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] req1 = '0;
  logic       abort1 = 1'b0;

  logic [3:0] enable, enable1;
  logic [1:0] grant_id, grant_id1;
  logic       busy, busy1, done, done1;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  rand_vs = 1'b0;

  msg_display_ctrl #(.N_REQ(4), .ID_W(2), .CNT_W(8), .SHOW_FRAMES(SHOW), .GAP_FRAMES(GAP)) dut (
    .pclk(pclk), .rst_n(rst_n), .vs_in(vs_in), .req(req), .abort(abort),
    .enable(enable), .grant_id(grant_id), .busy(busy), .done(done)
  );

  msg_display_ctrl #(.N_REQ(4), .ID_W(2), .CNT_W(8), .SHOW_FRAMES(SHOW), .GAP_FRAMES(0)) dut_nogap (
    .pclk(pclk), .rst_n(rst_n), .vs_in(vs_in), .req(req1), .abort(abort1),
    .enable(enable1), .grant_id(grant_id1), .busy(busy1), .done(done1)
  );

  always #5 pclk = ~pclk;

  // Reference: messages as countdowns of remaining frames, pending as a plain bit set.
  bit [3:0] mp, men;
  int       mlast, mmsg, mshow_left, mgap_left;
  bit       marmed, mkill, mvs, mbusy, mdone;

  task automatic model_reset();
    mp = '0; men = '0; mlast = 0; mmsg = 0; mshow_left = 0; mgap_left = 0;
    marmed = 0; mkill = 0; mvs = 0; mbusy = 0; mdone = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input bit ab, input bit vs);
    bit       tk;
    bit [3:0] np;
    tk = vs && !mvs;
    mvs = vs;
    mdone = 0;
    np = mp;
    if (!mbusy) begin
      if (!ab && mp != 0) begin
        for (int k = 4; k >= 1; k--) if (mp[(mlast + k) % 4]) mmsg = (mlast + k) % 4;
        mlast = mmsg;
        mbusy = 1;
        marmed = 1;
      end
    end else if (marmed) begin
      if (ab) begin
        mbusy = 0; marmed = 0;
      end else if (tk) begin
        marmed = 0; mshow_left = SHOW; men = 4'(1 << mmsg); np[mmsg] = 1'b0;
      end
    end else if (mshow_left > 0) begin
      if (ab) mkill = 1;
      if (mkill) begin
        if (tk) begin men = '0; mshow_left = 0; mbusy = 0; mkill = 0; end
      end else if (tk) begin
        mshow_left--;
        if (mshow_left == 0) begin
          men = '0; mdone = 1;
          if (GAP == 0) mbusy = 0; else mgap_left = GAP;
        end
      end
    end else begin
      if (ab) begin
        mgap_left = 0; mbusy = 0;
      end else if (tk) begin
        mgap_left--;
        if (mgap_left == 0) mbusy = 0;
      end
    end
    np = np | r;
    if (ab) np = '0;
    mp = np;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input bit ab, input logic [3:0] r1);
    @(negedge pclk);
    req = r; abort = ab; req1 = r1;
    cyc++;
    vs_in = rand_vs ? ($urandom_range(0, 7) == 0) : ((cyc % VS_PERIOD) < 3);
    @(posedge pclk);
    if (rst_n) model_step(r, ab, vs_in); else model_reset();
    #1;
    chk("model_enable", 32'(enable), 32'(men));
    chk("model_busy", 32'(busy), 32'(mbusy));
    chk("model_done", 32'(done), 32'(mdone));
    chk("model_grant_id", 32'(grant_id), 32'(mmsg));
    chk("onehot", 32'($countones(enable) <= 1), 32'd1);
    chk("onehot_nogap", 32'($countones(enable1) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, '0);
  endtask

  task automatic sync4();
    for (int i = 0; i < VS_PERIOD && (cyc % VS_PERIOD) != 4; i++) cycle('0, 1'b0, '0);
  endtask

  typedef struct {
    bit         sync;
    logic [3:0] req;
    int         ncyc;
    logic [3:0] en;
    bit         busy;
    logic [1:0] gid;
    bit         done;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // Round-robin order 1,3,0 from rr_ptr=0, then a single req[2] message.
    tbl[0]  = '{1'b1, 4'b1011,  2, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 14, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 50, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 10, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, 41, 4'b0000, 1'b1, 2'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 19, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 60, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[7]  = '{1'b0, 4'b0000, 41, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 19, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 60, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 4'b0000, 40, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{1'b1, 4'b0100,  2, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 14, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 40, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 19, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[15] = '{1'b0, 4'b0000,  1, 4'b0000, 1'b1, 2'd2, 1'b1};
    tbl[16] = '{1'b0, 4'b0000, 20, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 19, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[18] = '{1'b0, 4'b0000,  1, 4'b0000, 1'b0, 2'd2, 1'b0};

    model_reset();
    run(3);
    chk("reset_enable", 32'(enable), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    run(45);
    chk("idle_no_activity", 32'(busy), 32'd0);

    for (int v = 0; v < 19; v++) begin
      if (tbl[v].sync) sync4();
      for (int k = 0; k < tbl[v].ncyc; k++) cycle(k == 0 ? tbl[v].req : 4'b0000, 1'b0, '0);
      chk($sformatf("tbl%0d_enable", v), 32'(enable), 32'(tbl[v].en));
      chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      chk($sformatf("tbl%0d_grant_id", v), 32'(grant_id), 32'(tbl[v].gid));
      chk($sformatf("tbl%0d_done", v), 32'(done), 32'(tbl[v].done));
    end

    // Re-request during own SHOW re-shows once; a pulse during ARM adds nothing.
    sync4();
    cycle(4'b0010, 1'b0, '0);
    run(4);
    cycle(4'b0010, 1'b0, '0);
    run(10);
    chk("rereq_show1", 32'(enable), 32'b0010);
    run(9);
    cycle(4'b0010, 1'b0, '0);
    run(50);
    chk("rereq_done1", 32'(done), 32'd1);
    run(41);
    chk("rereq_armed_busy", 32'(busy), 32'd1);
    chk("rereq_armed_gid", 32'(grant_id), 32'd1);
    run(19);
    chk("rereq_show2", 32'(enable), 32'b0010);
    run(60);
    chk("rereq_done2", 32'(done), 32'd1);
    run(41);
    chk("rereq_no_third", 32'(busy), 32'd0);

    // Abort in the second SHOW frame with another message pending.
    sync4();
    cycle(4'b0001, 1'b0, '0);
    run(15);
    chk("abort_show", 32'(enable), 32'b0001);
    run(5);
    cycle(4'b1000, 1'b0, '0);
    run(19);
    cycle('0, 1'b1, '0);
    run(13);
    chk("abort_hold_enable", 32'(enable), 32'b0001);
    run(1);
    chk("abort_drop_enable", 32'(enable), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run(40);
    chk("abort_pending_dropped", 32'(busy), 32'd0);

    // Zero-gap build: second message armed right behind the first.
    sync4();
    cycle('0, 1'b0, 4'b0001);
    cycle('0, 1'b0, 4'b0010);
    run(74);
    chk("nogap_fall", 32'(enable1), 32'd0);
    chk("nogap_done", 32'(done1), 32'd1);
    chk("nogap_idle", 32'(busy1), 32'd0);
    run(1);
    chk("nogap_arm_busy", 32'(busy1), 32'd1);
    chk("nogap_arm_gid", 32'(grant_id1), 32'd1);
    run(18);
    chk("nogap_wait", 32'(enable1), 32'd0);
    run(1);
    chk("nogap_rise", 32'(enable1), 32'b0010);
    run(60);
    chk("nogap_done2", 32'(done1), 32'd1);
    run(20);

    // Asynchronous reset in the middle of a SHOW.
    sync4();
    cycle(4'b0100, 1'b0, '0);
    run(20);
    chk("midreset_show", 32'(enable), 32'b0100);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midreset_enable", 32'(enable), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(45);
    chk("midreset_quiet_busy", 32'(busy), 32'd0);
    chk("midreset_quiet_enable", 32'(enable), 32'd0);

    rand_vs = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      bit         ab;
      r  = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
      ab = ($urandom_range(0, 149) == 0);
      cycle(r, ab, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
